// File: rtl/ping_echo_responder_pkg.sv
// rtl/ping_echo_responder_pkg.sv - state encoding and shared default timing for the Sig ping responder
package ping_echo_responder_pkg;

  // Responder states; the 3-bit encoding is shared with the measurement block
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG    = 3'd1,
    S_HOLDOFF = 3'd2,
    S_ECHO    = 3'd3,
    S_TAIL    = 3'd4,
    S_GUARD   = 3'd5
  } state_t;

  // Default timing at 50 MHz; both ends of the Sig link use these values
  localparam int DEF_W        = 20;
  localparam int DEF_TRIG_MIN = 100;     // 2 us
  localparam int DEF_HOLDOFF  = 37500;   // 750 us
  localparam int DEF_ECHO_MIN = 5750;    // 115 us
  localparam int DEF_ECHO_MAX = 925000;  // 18.5 ms, also the no-object width
  localparam int DEF_GUARD    = 10000;

  // States in which the responder is committed to a ping and ignores Sig
  function automatic logic is_busy(input state_t s);
    return (s == S_HOLDOFF) || (s == S_ECHO) || (s == S_TAIL) || (s == S_GUARD);
  endfunction

endpackage

// File: rtl/ping_echo_responder_sync_edge.sv
// rtl/ping_echo_responder_sync_edge.sv - 2-FF synchronizer with previous-sample edge detect
module ping_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic din,
  output logic s2,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2_d;

  // Two-stage synchronizer plus one extra stage for edge detection
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign rise = ~s2_d & s2;
  assign fall = s2_d & ~s2;

endmodule

// File: rtl/ping_echo_responder.sv
// rtl/ping_echo_responder.sv - ultrasonic range sensor emulator answering triggers on the Sig pin
module ping_echo_responder
  import ping_echo_responder_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int TRIG_MIN = DEF_TRIG_MIN,
  parameter int HOLDOFF  = DEF_HOLDOFF,
  parameter int ECHO_MIN = DEF_ECHO_MIN,
  parameter int ECHO_MAX = DEF_ECHO_MAX,
  parameter int GUARD    = DEF_GUARD
) (
  input  logic         CLK,
  input  logic         RESET,
  inout  wire logic    Sig,
  input  logic [W-1:0] DIST,
  output logic         BUSY,
  output logic         ECHO_ACTIVE,
  output logic         SHORT_TRIG,
  output logic [7:0]   PING_CNT
);

  localparam logic [W-1:0] TRIG_MIN_W = W'(TRIG_MIN);
  localparam logic [W-1:0] HOLDOFF_W  = W'(HOLDOFF);
  localparam logic [W-1:0] ECHO_MIN_W = W'(ECHO_MIN);
  localparam logic [W-1:0] ECHO_MAX_W = W'(ECHO_MAX);
  localparam logic [W-1:0] GUARD_W    = W'(GUARD);
  localparam logic [W-1:0] ONE_W      = W'(1);

  state_t       state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [W-1:0] width, width_n;
  logic [7:0]   ping_n;
  logic         sig_oe, sig_oe_n;
  logic         sig_do, sig_do_n;
  logic         short_n;

  logic s2;
  logic rise;
  logic fall;
  logic unused_rise;

  assign unused_rise = rise;

  // Zero means no object, which the real sensor reports as a maximum-width echo
  function automatic logic [W-1:0] clamp_width(input logic [W-1:0] d);
    if (d == '0)              return ECHO_MAX_W;
    else if (d < ECHO_MIN_W)  return ECHO_MIN_W;
    else if (d > ECHO_MAX_W)  return ECHO_MAX_W;
    else                      return d;
  endfunction

  ping_sync_edge u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .din   (Sig),
    .s2    (s2),
    .rise  (rise),
    .fall  (fall)
  );

  // Pad is released straight from the registered enable, so reset frees it at once
  assign Sig = sig_oe ? sig_do : 1'bz;

  // Next-state, counter and pin-drive decode; one shared counter serves every timed state
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    width_n  = width;
    ping_n   = PING_CNT;
    sig_oe_n = 1'b0;
    sig_do_n = 1'b0;
    short_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (s2) begin
          state_n = S_TRIG;
          cnt_n   = ONE_W;
        end
      end
      S_TRIG: begin
        if (fall) begin
          cnt_n = '0;
          if (cnt >= TRIG_MIN_W) begin
            state_n = S_HOLDOFF;
            width_n = clamp_width(DIST);
            ping_n  = PING_CNT + 8'd1;
          end else begin
            state_n = S_IDLE;
            short_n = 1'b1;
          end
        end else if (s2 && (cnt < TRIG_MIN_W)) begin
          cnt_n = cnt + ONE_W;
        end
      end
      S_HOLDOFF: begin
        if (cnt == HOLDOFF_W - ONE_W) begin
          state_n  = S_ECHO;
          cnt_n    = '0;
          sig_oe_n = 1'b1;
          sig_do_n = 1'b1;
        end else begin
          cnt_n = cnt + ONE_W;
        end
      end
      S_ECHO: begin
        sig_oe_n = 1'b1;
        if (cnt == width - ONE_W) begin
          state_n  = S_TAIL;
          cnt_n    = '0;
          sig_do_n = 1'b0;
        end else begin
          cnt_n    = cnt + ONE_W;
          sig_do_n = 1'b1;
        end
      end
      S_TAIL: begin
        state_n = S_GUARD;
        cnt_n   = '0;
      end
      S_GUARD: begin
        if (cnt == GUARD_W - ONE_W) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE_W;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      cnt         <= '0;
      width       <= '0;
      sig_oe      <= 1'b0;
      sig_do      <= 1'b0;
      BUSY        <= 1'b0;
      ECHO_ACTIVE <= 1'b0;
      SHORT_TRIG  <= 1'b0;
      PING_CNT    <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      width       <= width_n;
      sig_oe      <= sig_oe_n;
      sig_do      <= sig_do_n;
      BUSY        <= is_busy(state_n);
      ECHO_ACTIVE <= sig_oe_n & sig_do_n;
      SHORT_TRIG  <= short_n;
      PING_CNT    <= ping_n;
    end
  end

endmodule

// File: tb/tb_ping_echo_responder.sv
// tb/tb_ping_echo_responder.sv - scoreboard bench for ping_echo_responder
module tb_ping_echo_responder;

  localparam int W    = 20;
  localparam int TMIN = 4;
  localparam int HOFF = 10;
  localparam int EMIN = 100;
  localparam int EMAX = 3000;
  localparam int GRD  = 5;

  localparam int K_ECHO  = 0;
  localparam int K_SHORT = 1;
  localparam int K_NONE  = 2;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] DIST = '0;
  logic         tb_drv = 1'b0;
  wire          sig;
  logic         BUSY;
  logic         ECHO_ACTIVE;
  logic         SHORT_TRIG;
  logic [7:0]   PING_CNT;

  assign sig = tb_drv ? 1'b1 : 1'bz;
  pulldown (sig);

  ping_echo_responder #(
    .W        (W),
    .TRIG_MIN (TMIN),
    .HOLDOFF  (HOFF),
    .ECHO_MIN (EMIN),
    .ECHO_MAX (EMAX),
    .GUARD    (GRD)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Sig         (sig),
    .DIST        (DIST),
    .BUSY        (BUSY),
    .ECHO_ACTIVE (ECHO_ACTIVE),
    .SHORT_TRIG  (SHORT_TRIG),
    .PING_CNT    (PING_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;
    int width;
    int start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pad high for n sampled edges, then released; first low sample is the next edge (E0),
  // so the echo must first be seen after edge E0+2+HOFF, i.e. cyc+3+HOFF at release time
  task automatic trig(input int n, input int kind, input int width_exp);
    exp_t e;
    @(posedge CLK); #2 tb_drv = 1'b1;
    repeat (n) @(posedge CLK);
    #2 tb_drv = 1'b0;
    e.kind  = kind;
    e.width = width_exp;
    e.start = cyc + 3 + HOFF;
    if (kind != K_NONE) sb.push_back(e);
  endtask

  task automatic wait_idle();
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 5000 && BUSY; i++) @(negedge CLK);
    if (BUSY) chk("idle_timeout", 1, 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_echo();
    for (int i = 0; i < 200 && !ECHO_ACTIVE; i++) @(negedge CLK);
    if (!ECHO_ACTIVE) chk("echo_timeout", 0, 1);
  endtask

  // Monitor: measures each echo pulse and every SHORT_TRIG, popping the scoreboard
  bit in_pulse = 1'b0;
  bit tail_chk = 1'b0;
  int p_start, p_len, p_bad;

  always @(negedge CLK) begin
    if (RESET) begin
      in_pulse = 1'b0;
      tail_chk = 1'b0;
    end else begin
      if (tail_chk) begin
        chk("release_z", int'(dut.sig_oe), 0);
        tail_chk = 1'b0;
      end
      if (ECHO_ACTIVE) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          p_start  = cyc;
          p_len    = 0;
          p_bad    = 0;
        end
        p_len++;
        if (sig !== 1'b1 || BUSY !== 1'b1) p_bad++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        tail_chk = 1'b1;
        chk("tail_drive_low", int'(sig === 1'b0 && dut.sig_oe === 1'b1), 1);
        chk("echo_level", p_bad, 0);
        if (sb.size() == 0) chk("unexpected_echo", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("echo_kind", K_ECHO, mon_e.kind);
          chk("echo_width", p_len, mon_e.width);
          chk("echo_start", p_start, mon_e.start);
        end
      end
      if (SHORT_TRIG) begin
        if (sb.size() == 0) chk("unexpected_short", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("short_kind", K_SHORT, mon_e.kind);
        end
      end
    end
  end

  int dv[8] = '{0, 'hFFFFF, 99, 100, 3000, 3001, 2999, 10};
  int ew[8] = '{EMAX, EMAX, EMIN, EMIN, EMAX, EMAX, 2999, EMIN};
  int busy_hits, oe_hits;

  initial begin
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_echo", int'(ECHO_ACTIVE), 0);
    chk("rst_short", int'(SHORT_TRIG), 0);
    chk("rst_ping", int'(PING_CNT), 0);
    chk("rst_oe", int'(dut.sig_oe), 0);

    // normal ping
    DIST = 20'd2000;
    trig(6, K_ECHO, 2000);
    wait_idle();
    chk("ping_normal", int'(PING_CNT), 1);

    // short trigger: rejected, pin never driven, never busy
    trig(3, K_SHORT, 0);
    busy_hits = 0;
    oe_hits = 0;
    repeat (20) begin
      @(negedge CLK);
      if (BUSY) busy_hits++;
      if (dut.sig_oe) oe_hits++;
    end
    chk("short_busy", busy_hits, 0);
    chk("short_oe", oe_hits, 0);
    chk("ping_short", int'(PING_CNT), 1);

    // trigger exactly TRIG_MIN long is accepted
    DIST = 20'd500;
    trig(TMIN, K_ECHO, 500);
    wait_idle();
    chk("ping_min_trig", int'(PING_CNT), 2);

    // clamping table
    for (int i = 0; i < 8; i++) begin
      DIST = W'(dv[i]);
      trig(6, K_ECHO, ew[i]);
      wait_idle();
    end
    chk("ping_clamp", int'(PING_CNT), 10);

    // DIST change and retrigger while busy
    DIST = 20'd500;
    trig(6, K_ECHO, 500);
    wait_echo();
    repeat (20) @(negedge CLK);
    DIST = 20'd900;
    @(posedge CLK); #2 tb_drv = 1'b1;
    repeat (8) @(posedge CLK);
    #2 tb_drv = 1'b0;
    for (int i = 0; i < 2000 && ECHO_ACTIVE; i++) @(negedge CLK);
    @(posedge CLK); #2 tb_drv = 1'b1;
    @(posedge CLK); #2 tb_drv = 1'b0;
    DIST = 20'd0;
    wait_idle();
    repeat (10) @(negedge CLK);
    chk("ping_retrig", int'(PING_CNT), 11);

    // reset mid-echo releases the pin immediately
    DIST = 20'd1000;
    trig(6, K_NONE, 0);
    wait_echo();
    repeat (100) @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_oe", int'(dut.sig_oe), 0);
    chk("rst_mid_pin", int'(sig === 1'b1), 0);
    chk("rst_mid_busy", int'(BUSY), 0);
    chk("rst_mid_echo", int'(ECHO_ACTIVE), 0);
    chk("rst_mid_ping", int'(PING_CNT), 0);
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;
    trig(6, K_ECHO, 1000);
    wait_idle();
    chk("ping_after_rst", int'(PING_CNT), 1);

    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
